// File: rtl/trng_word_reader.sv
// Consumer end of the ring-oscillator TRNG word path: repetition-count health test,
// small word FIFO, and byte-wise four-phase req/ack egress to an off-chip host.
module trng_word_reader #(
  parameter int WORD_W    = 16,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [WORD_W-1:0]        src_word,
  input  logic                     src_valid,
  input  logic                     rd_req,
  output logic [7:0]               rd_data,
  output logic                     rd_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     health_fail
);

  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [REP_W-1:0] REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, next_s;
  logic                    req_meta_r, req_sync_r;
  logic [WORD_W-1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [IDX_W-1:0]        idx_r;
  logic [WORD_W-1:0]       prev_word_r;
  logic                    prev_valid_r;
  logic [REP_W-1:0]        rep_cnt_r, rep_next_s;
  logic                    health_fail_r, overflow_r, rd_ack_r;
  logic [7:0]              rd_data_r, byte_s;
  logic [WORD_W-1:0]       head_s;
  logic                    ing_s, same_s, trip_s, pop_s, space_s, push_s, drop_s;

  assign rd_data     = rd_data_r;
  assign rd_ack      = rd_ack_r;
  assign fifo_count  = count_r;
  assign overflow    = overflow_r;
  assign health_fail = health_fail_r;

  // Ingress qualification, repetition count and push/drop decision.
  always_comb begin
    ing_s  = src_valid && en && !health_fail_r;
    same_s = prev_valid_r && (src_word == prev_word_r);
    if (same_s) begin
      if (rep_cnt_r == REP_MAX) begin
        rep_next_s = REP_MAX;
      end else begin
        rep_next_s = rep_cnt_r + REP_W'(1);
      end
    end else begin
      rep_next_s = REP_W'(1);
    end
    trip_s  = ing_s && (rep_next_s == REP_MAX);
    // A trip flushes the FIFO, so it suppresses any pop in the same cycle.
    pop_s   = (state_r == DONE) && (idx_r == IDX_LAST) && !trip_s;
    space_s = (count_r < CNT_FULL) || pop_s;
    push_s  = ing_s && !trip_s && space_s;
    drop_s  = ing_s && !trip_s && !space_s;
  end

  // Little-endian byte select from the FIFO head.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    byte_s = 8'(head_s >> {idx_r, 3'b000});
  end

  // Egress next-state logic.
  always_comb begin
    next_s = state_r;
    if (trip_s) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_sync_r && (count_r != '0) && !health_fail_r) begin
            next_s = ACK;
          end else begin
            next_s = IDLE;
          end
        end
        ACK: begin
          if (!req_sync_r) begin
            next_s = DONE;
          end else begin
            next_s = ACK;
          end
        end
        DONE:    next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the host request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_meta_r <= 1'b0;
      req_sync_r <= 1'b0;
    end else begin
      req_meta_r <= rd_req;
      req_sync_r <= req_meta_r;
    end
  end

  // Egress state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Health test state and sticky status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_word_r   <= '0;
      prev_valid_r  <= 1'b0;
      rep_cnt_r     <= '0;
      health_fail_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (ing_s) begin
        prev_word_r  <= src_word;
        prev_valid_r <= 1'b1;
        rep_cnt_r    <= rep_next_s;
      end
      if (trip_s) begin
        health_fail_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Word FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (trip_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= src_word;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Byte index, presented data and acknowledge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_r     <= '0;
      rd_data_r <= 8'h00;
      rd_ack_r  <= 1'b0;
    end else begin
      rd_ack_r <= (state_r == ACK) && !trip_s && !health_fail_r;
      if (trip_s) begin
        idx_r <= '0;
      end else if (state_r == DONE) begin
        if (idx_r == IDX_LAST) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
      if ((state_r == IDLE) && (next_s == ACK)) begin
        rd_data_r <= byte_s;
      end
    end
  end

endmodule

// File: tb/tb_trng_word_reader.sv
// Directed bench for trng_word_reader: expected host bytes are queued when words are
// pushed and checked as each handshake completes.
module tb_trng_word_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b1;
  logic [15:0] src_word = 16'h0000;
  logic        src_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        health_fail;

  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          passes = 0;

  trng_word_reader #(.WORD_W(16), .DEPTH(4), .REP_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST), .en(en), .src_word(src_word), .src_valid(src_valid),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack), .fifo_count(fifo_count),
    .overflow(overflow), .health_fail(health_fail)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; src_valid = 1'b0; rd_req = 1'b0; en = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [15:0] w, input bit accept);
    @(negedge CLK);
    src_word = w; src_valid = 1'b1;
    if (accept) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
    @(negedge CLK);
    src_valid = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (rd_ack !== lvl && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic next_exp(output logic [7:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  task automatic read_byte(input string tag, input bit check_lat);
    int cyc;
    logic [7:0] e;
    @(negedge CLK);
    rd_req = 1'b1;
    wait_ack(1'b1, 20, cyc);
    chk({tag, " ack"}, rd_ack, 1);
    if (check_lat) chk({tag, " rise latency"}, cyc, 4);
    next_exp(e);
    chk({tag, " data"}, rd_data, e);
    rd_req = 1'b0;
    wait_ack(1'b0, 20, cyc);
    chk({tag, " release"}, rd_ack, 0);
    if (check_lat) chk({tag, " fall latency"}, cyc, 4);
  endtask

  initial begin
    int cyc;
    logic [7:0] e;

    // Reset values
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset rd_ack", rd_ack, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset overflow", overflow, 0);
    chk("reset health_fail", health_fail, 0);

    // 1: two words, four handshakes, little-endian
    push(16'hA1B2, 1);
    push(16'hC3D4, 1);
    chk("t1 count2", fifo_count, 2);
    read_byte("t1 b0", 1);
    read_byte("t1 b1", 0);
    chk("t1 count1", fifo_count, 1);
    read_byte("t1 b2", 0);
    read_byte("t1 b3", 0);
    chk("t1 count0", fifo_count, 0);

    // 2: request on empty FIFO, then push while request is held
    do_reset();
    @(negedge CLK);
    rd_req = 1'b1;
    repeat (8) @(negedge CLK);
    chk("t2 empty no ack", rd_ack, 0);
    push(16'h1234, 1);
    wait_ack(1'b1, 4, cyc);
    chk("t2 ack after push", rd_ack, 1);
    next_exp(e);
    chk("t2 data", rd_data, e);
    rd_req = 1'b0;
    wait_ack(1'b0, 20, cyc);
    chk("t2 release", rd_ack, 0);
    read_byte("t2 b1", 0);

    // 3: DEPTH+1 words without reads
    do_reset();
    push(16'h1111, 1);
    push(16'h2222, 1);
    push(16'h3333, 1);
    push(16'h4444, 1);
    push(16'h5556, 0);
    chk("t3 count full", fifo_count, 4);
    chk("t3 overflow", overflow, 1);
    for (int i = 0; i < 8; i++) read_byte("t3 drain", 0);
    chk("t3 count empty", fifo_count, 0);

    // 4: repetition test trips on the REP_LIMIT-th identical word
    do_reset();
    for (int i = 0; i < 7; i++) push(16'h5555, i < 4);
    chk("t4 no fail yet", health_fail, 0);
    push(16'h5555, 0);
    exp_q.delete();
    chk("t4 health_fail", health_fail, 1);
    chk("t4 flushed", fifo_count, 0);
    push(16'h7777, 0);
    chk("t4 no push", fifo_count, 0);
    @(negedge CLK);
    rd_req = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t4 no ack", rd_ack, 0);
    rd_req = 1'b0;
    do_reset();
    chk("t4 cleared", health_fail, 0);

    // 5: push coincides with last-byte pop on a full FIFO
    do_reset();
    push(16'h1A2B, 1);
    push(16'h3C4D, 1);
    push(16'h5E6F, 1);
    push(16'h7081, 1);
    chk("t5 full", fifo_count, 4);
    read_byte("t5 b0", 0);
    @(negedge CLK);
    rd_req = 1'b1;
    wait_ack(1'b1, 20, cyc);
    chk("t5 b1 ack", rd_ack, 1);
    next_exp(e);
    chk("t5 b1 data", rd_data, e);
    rd_req = 1'b0;
    repeat (3) @(negedge CLK);
    src_word = 16'h9293; src_valid = 1'b1;
    exp_q.push_back(8'h93);
    exp_q.push_back(8'h92);
    @(negedge CLK);
    src_valid = 1'b0;
    chk("t5 count stays", fifo_count, 4);
    chk("t5 no overflow", overflow, 0);
    for (int i = 0; i < 8; i++) read_byte("t5 drain", 0);
    chk("t5 empty", fifo_count, 0);

    // 6: reset while acknowledged
    do_reset();
    push(16'hBEEF, 1);
    @(negedge CLK);
    rd_req = 1'b1;
    wait_ack(1'b1, 20, cyc);
    chk("t6 ack", rd_ack, 1);
    RST = 1'b1;
    #1;
    chk("t6 async ack drop", rd_ack, 0);
    chk("t6 count cleared", fifo_count, 0);
    @(negedge CLK);
    rd_req = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    push(16'hCAFE, 1);
    read_byte("t6 b0", 0);
    read_byte("t6 b1", 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
